// File: rtl/pico_seq_ctrl.sv
// Multi-cycle sequencer for picoMIPS: gates PC advance and register writes for LOAD, MULI and NOP.
// Optional button debounce filter enabled by defining SW_DEBOUNCE_EN.
module pico_seq_ctrl #(
  parameter int MUL_LAT         = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [2:0] opcode,
  input  logic       dec_write,
  input  logic       btn,
  output logic       pc_en,
  output logic       rf_we,
  output logic       mul_busy,
  output logic       load_wait,
  output logic       halted,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_MULI = 3'd3;
  localparam logic [2:0] OP_LOAD = 3'd4;

  typedef enum logic [2:0] {
    EXEC      = 3'd0,
    LOAD_ARM  = 3'd1,
    LOAD_WAIT = 3'd2,
    MUL       = 3'd3,
    HALT      = 3'd4
  } state_t;

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("pico_seq_ctrl: MUL_LAT must be in 1..15");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pico_seq_ctrl: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("pico_seq_ctrl: DEBOUNCE_CYCLES must be at least 1");
  end

  state_t                 state;
  logic [3:0]             mul_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic pc_en_c, rf_we_c, mul_busy_c, load_wait_c, halted_c;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

`ifdef SW_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [DW-1:0] db_cnt;
  logic          btn_f;

  // btn_f flips on the last of DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      db_cnt <= '0;
      btn_f  <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == btn_f) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      btn_f  <= sync_q[SYNC_STAGES-1];
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
  assign btn_s = btn_f;
`else
  assign btn_s = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= EXEC;
      mul_cnt <= 4'd0;
    end else begin
      case (state)
        EXEC: begin
          case (opcode)
            OP_LOAD: state <= LOAD_ARM;
            OP_MULI: begin
              state   <= MUL;
              mul_cnt <= 4'(MUL_LAT - 1);
            end
            OP_NOP:  state <= HALT;
            default: state <= EXEC;
          endcase
        end
        // A button already held at LOAD issue must be released before it counts
        LOAD_ARM:  if (!btn_s) state <= LOAD_WAIT;
        LOAD_WAIT: if (btn_s) state <= EXEC;
        MUL: begin
          if (mul_cnt == 4'd0) state <= EXEC;
          else                 mul_cnt <= mul_cnt - 4'd1;
        end
        HALT:    state <= HALT;
        default: state <= EXEC;
      endcase
    end
  end

  always_comb begin
    pc_en_c     = 1'b0;
    rf_we_c     = 1'b0;
    mul_busy_c  = 1'b0;
    load_wait_c = 1'b0;
    halted_c    = 1'b0;
    case (state)
      EXEC: begin
        case (opcode)
          OP_LOAD, OP_NOP: ;
          OP_MULI: mul_busy_c = 1'b1;
          default: begin
            pc_en_c = 1'b1;
            rf_we_c = dec_write;
          end
        endcase
      end
      LOAD_ARM: load_wait_c = 1'b1;
      LOAD_WAIT: begin
        load_wait_c = 1'b1;
        pc_en_c     = btn_s;
        rf_we_c     = btn_s;
      end
      MUL: begin
        mul_busy_c = 1'b1;
        pc_en_c    = (mul_cnt == 4'd0);
        rf_we_c    = (mul_cnt == 4'd0);
      end
      HALT:    halted_c = 1'b1;
      default: ;
    endcase
  end

  // Mealy outputs are forced low while reset is held, so an aborted op never writes
  assign pc_en     = pc_en_c     & n_reset;
  assign rf_we     = rf_we_c     & n_reset;
  assign mul_busy  = mul_busy_c  & n_reset;
  assign load_wait = load_wait_c & n_reset;
  assign halted    = halted_c    & n_reset;
  assign state_dbg = state;

  logic unused_ops;
  assign unused_ops = ^{OP_ADD, OP_ADDI};

endmodule

// File: tb/tb_pico_seq_ctrl.sv
// Scoreboard bench for pico_seq_ctrl: random stimulus checked against a cycle-level reference model.
module tb_pico_seq_ctrl;
  localparam int MUL_LAT         = 3;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 16;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_MULI = 3'd3;
  localparam logic [2:0] OP_LOAD = 3'd4;

  // model modes use the same numbers as state_dbg
  localparam int M_RUN = 0, M_ARM = 1, M_WAIT = 2, M_MUL = 3, M_HALT = 4;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [2:0] opcode = OP_ADD;
  logic       dec_write = 1'b0;
  logic       btn = 1'b0;
  logic       pc_en, rf_we, mul_busy, load_wait, halted;
  logic [2:0] state_dbg;

  pico_seq_ctrl #(
    .MUL_LAT(MUL_LAT), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk(clk), .n_reset(n_reset), .opcode(opcode), .dec_write(dec_write), .btn(btn),
    .pc_en(pc_en), .rf_we(rf_we), .mul_busy(mul_busy), .load_wait(load_wait),
    .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  int mode = M_RUN;
  int mul_done_at = 0;
  int halt_len = 0;
  bit hist[$];
  bit f_model = 1'b0;
  int run_len = 0;

  // one line of expected outputs per cycle: {state, halted, load_wait, mul_busy, rf_we, pc_en}
  task automatic model_step(input logic [2:0] op, input logic dw, input logic b, input logic rst_low);
    logic pc, rf, mb, lw, h, bs, eff;
    int nxt;
    pc = 0; rf = 0; mb = 0; lw = 0; h = 0;
    if (rst_low) begin
      exp_q.push_back(8'h00);
      mode = M_RUN;
      hist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
      f_model = 1'b0;
      run_len = 0;
      cycle_no++;
      return;
    end
    bs = hist[0];
`ifdef SW_DEBOUNCE_EN
    eff = f_model;
`else
    eff = bs;
`endif
    nxt = mode;
    case (mode)
      M_RUN: begin
        if (op == OP_LOAD) nxt = M_ARM;
        else if (op == OP_MULI) begin
          mb = 1; nxt = M_MUL; mul_done_at = cycle_no + MUL_LAT;
        end
        else if (op == OP_NOP) nxt = M_HALT;
        else begin pc = 1; rf = dw; end
      end
      M_ARM: begin lw = 1; if (!eff) nxt = M_WAIT; end
      M_WAIT: begin
        lw = 1;
        if (eff) begin pc = 1; rf = 1; nxt = M_RUN; end
      end
      M_MUL: begin
        mb = 1;
        if (cycle_no == mul_done_at) begin pc = 1; rf = 1; nxt = M_RUN; end
      end
      default: h = 1;
    endcase
    exp_q.push_back({3'(mode), h, lw, mb, rf, pc});
    mode = nxt;
    void'(hist.pop_front());
    hist.push_back(b);
    if (bs != f_model) run_len++; else run_len = 0;
    if (run_len == DEBOUNCE_CYCLES) begin f_model = bs; run_len = 0; end
    cycle_no++;
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic dw, input logic b, input logic rst_low);
    @(posedge clk);
    #1;
    n_reset   = !rst_low;
    opcode    = op;
    dec_write = dw;
    btn       = b;
    model_step(op, dw, b, rst_low);
  endtask

  task automatic check_output(input logic [7:0] e);
    logic [7:0] got;
    got = {state_dbg, halted, load_wait, mul_busy, rf_we, pc_en};
    checks++;
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL outputs cycle %0d: got state=%0d h=%b lw=%b mb=%b rf=%b pc=%b, expected state=%0d h=%b lw=%b mb=%b rf=%b pc=%b",
               cycle_no, got[7:5], got[4], got[3], got[2], got[1], got[0],
               e[7:5], e[4], e[3], e[2], e[1], e[0]);
    end
  endtask

  // Monitor: compares whatever the stimulus side predicted for this cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [2:0] rand_op();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 30) return OP_ADD;
    if (r < 45) return OP_ADDI;
    if (r < 52) return 3'(5 + $urandom_range(0, 2));
    if (r < 68) return OP_LOAD;
    if (r < 84) return OP_MULI;
    if (r < 86) return OP_NOP;
    return OP_ADD;
  endfunction

  initial begin
    logic b;
    int hold;
    int max_hold;
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
`ifdef SW_DEBOUNCE_EN
    max_hold = 40;
`else
    max_hold = 8;
`endif
    $display("[TB] start");
    apply_stimulus(OP_ADD, 1, 0, 1);
    apply_stimulus(OP_ADD, 1, 0, 1);
    // ADD held three cycles with writes
    repeat (3) apply_stimulus(OP_ADD, 1, 0, 0);
    // MULI then ignored opcodes while busy
    apply_stimulus(OP_MULI, 0, 0, 0);
    repeat (MUL_LAT) apply_stimulus(rand_op(), 1'($urandom), 0, 0);
    // LOAD with button already held, then release and press
    repeat (3) apply_stimulus(OP_ADD, 0, 1, 0);
    apply_stimulus(OP_LOAD, 0, 1, 0);
    repeat (4) apply_stimulus(OP_LOAD, 0, 1, 0);
    repeat (3 + DEBOUNCE_CYCLES) apply_stimulus(OP_ADD, 0, 0, 0);
    repeat (4 + DEBOUNCE_CYCLES) apply_stimulus(OP_ADD, 1, 1, 0);
    repeat (3 + DEBOUNCE_CYCLES) apply_stimulus(OP_ADD, 1, 0, 0);
    // reset during the second MUL cycle
    apply_stimulus(OP_MULI, 1, 0, 0);
    apply_stimulus(OP_ADD, 1, 0, 0);
    apply_stimulus(OP_ADD, 1, 0, 1);
    apply_stimulus(OP_ADD, 1, 0, 0);
    // halt is sticky for 20 cycles until reset
    apply_stimulus(OP_NOP, 0, 0, 0);
    repeat (20) apply_stimulus(rand_op(), 1'($urandom), 1'($urandom), 0);
    apply_stimulus(OP_ADD, 0, 0, 1);
    // LOAD waiting: short glitch, then long press
    apply_stimulus(OP_LOAD, 0, 0, 0);
    repeat (30) apply_stimulus(OP_ADD, 0, 0, 0);
    repeat (10) apply_stimulus(OP_ADD, 0, 1, 0);
    repeat (30) apply_stimulus(OP_ADD, 0, 0, 0);
    repeat (20) apply_stimulus(OP_ADD, 0, 1, 0);
    repeat (30) apply_stimulus(OP_ADD, 0, 0, 0);

    b = 1'b0;
    hold = 1;
    halt_len = 0;
    for (int n = 0; n < 4000; n++) begin
      hold--;
      if (hold <= 0) begin
        b = !b;
        hold = int'($urandom_range(1, max_hold));
      end
      if (mode == M_HALT) halt_len++; else halt_len = 0;
      if (halt_len > 20 || $urandom_range(0, 249) == 0) begin
        apply_stimulus(rand_op(), 1'($urandom), b, 1);
        halt_len = 0;
      end else begin
        apply_stimulus(rand_op(), 1'($urandom), b, 0);
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pico_seq_ctrl.md
Name: pico_seq_ctrl

Overview:
- Multi-cycle sequencer for the picoMIPS core. Sits between the opcode decoder and the PC/register-file enables.
- Takes the 3-bit opcode and the decoder's write strobe, and issues the actual PC advance and register write enables.
- LOAD stalls until a fresh button press is seen on the switch input. MULI is held for a fixed multiplier latency. NOP halts the core.
- Overrides the decoder's PCincr; the decoder's ALUFunc, imm and imm_or_sw pass to the datapath unchanged.

Parameters:
- MUL_LAT, 3, extra cycles the multiplier needs after issue; legal range 1..15.
- SYNC_STAGES, 2, flops in the button synchroniser; legal range 2..4.
- DEBOUNCE_CYCLES, 16, stable-cycle count for the debounce filter; used only with SW_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock, rising edge
- n_reset  in  1  asynchronous active-low reset
- opcode  in  3  current instruction opcode; encodings from opcodes.sv
- dec_write  in  1  decoder write strobe
- btn  in  1  raw asynchronous button, active high
- pc_en  out  1  PC advances at the next clock edge
- rf_we  out  1  register file writes at the next clock edge
- mul_busy  out  1  multiply in progress; the datapath holds its operands
- load_wait  out  1  waiting for the button (LED drive)
- halted  out  1  core halted
- state_dbg  out  3  current state encoding: EXEC=0, LOAD_ARM=1, LOAD_WAIT=2, MUL=3, HALT=4

Behaviour:
- Reset and clocking:
  - Single clock, clk. Reset is asynchronous and active-low on n_reset.
  - While n_reset=0: state=EXEC, multiply counter=0, synchroniser flops=0.
  - While n_reset=0 all outputs are 0: pc_en=0, rf_we=0, mul_busy=0, load_wait=0, halted=0.
- Button path: btn passes through SYNC_STAGES flops to give btn_s. Press-to-visible latency is SYNC_STAGES cycles.
- Outputs are combinational from state, opcode and btn_s (Mealy). The state register updates at the rising edge.
- EXEC state, by opcode:
  - ADD, ADDI, or any unlisted opcode: pc_en=1, rf_we=dec_write; stay in EXEC. One cycle per instruction.
  - LOAD: pc_en=0, rf_we=0; next state is LOAD_ARM.
  - MULI: pc_en=0, rf_we=0, mul_busy=1; counter loads MUL_LAT-1; next state is MUL.
  - NOP: pc_en=0, rf_we=0; next state is HALT.
- LOAD_ARM state:
  - Outputs: load_wait=1, pc_en=0, rf_we=0.
  - btn_s=0 moves to LOAD_WAIT. A button already held when LOAD issued is not accepted; a release is required first.
- LOAD_WAIT state:
  - Outputs: load_wait=1.
  - When btn_s=1: rf_we=1 and pc_en=1 in that same cycle, so the switch value is written once; next state is EXEC.
  - Otherwise hold with pc_en=0, rf_we=0.
- MUL state:
  - Outputs: mul_busy=1.
  - Counter nonzero: decrement; pc_en=0, rf_we=0.
  - Counter=0: rf_we=1, pc_en=1; next state is EXEC.
  - MULI occupies exactly MUL_LAT+1 cycles, counting the EXEC issue cycle.
- HALT state:
  - Outputs: halted=1, pc_en=0, rf_we=0.
  - Sticky; only n_reset leaves it.
- Boundary conditions:
  - The opcode input is ignored outside EXEC. The PC is frozen there, so the opcode is stable anyway.
  - Button bouncing during LOAD_WAIT: only the first btn_s=1 cycle is accepted. The next LOAD must re-arm through a release.
  - Reset mid-LOAD or mid-MUL aborts immediately. No write occurs, and the core returns to EXEC.
- Counter width is 4 bits. MUL_LAT outside 1..15 is a configuration error; add an elaboration-time assertion.
- state_dbg always reflects the registered state.

Optional Feature:
- Macro: SW_DEBOUNCE_EN.
- When defined:
  - btn_s is replaced by a filtered signal btn_f.
  - btn_f changes only after the synchronised input differs from btn_f for DEBOUNCE_CYCLES consecutive cycles.
  - A counter of clog2(DEBOUNCE_CYCLES+1) bits resets to 0 on any mismatch break. Its reset value is 0, and btn_f resets to 0.
  - Press latency becomes SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- When undefined: the synchroniser output is used directly and no filter logic is present.

Test Plan:
- Reset, then ADD with dec_write=1 held 3 cycles -> pc_en=1 and rf_we=1 every cycle, state_dbg=0.
- MULI with MUL_LAT=3 -> mul_busy=1 for 4 cycles; pc_en=rf_we=1 only in the 4th cycle; then back to EXEC.
- LOAD issued with btn held high -> stays in LOAD_ARM (load_wait=1, no writes). Release, then press -> exactly one cycle of rf_we=1, pc_en=1, then EXEC.
- NOP -> halted=1 from the next cycle; pc_en stays 0 for 20 cycles whatever the opcode; n_reset pulse -> halted=0, state EXEC.
- n_reset asserted in the 2nd MUL cycle -> all outputs 0 immediately, with no rf_we pulse ever.
- SW_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=16, LOAD waiting -> a 10-cycle btn glitch is ignored; a 20-cycle press gives one write SYNC_STAGES+16 cycles after the press.
